// File: rtl/ks_pkg.sv
// ks_pkg: shared prefix types, combine operator and clog2 for the Kogge-Stone adder.
package ks_pkg;
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic gp_t gp_comb(input gp_t h, input gp_t l);
    return '{g: h.g | (h.p & l.g), p: h.p & l.p};
  endfunction
endpackage

// File: rtl/ks_prefix_level.sv
// ks_prefix_level: one combinational Kogge-Stone level combining each node with the node SPAN below.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SPAN  = 1
) (
  input  gp_t [WIDTH-1:0] gp_i,
  output gp_t [WIDTH-1:0] gp_o
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= SPAN) begin : g_cmb
      assign gp_o[i] = gp_comb(gp_i[i], gp_i[i-SPAN]);
    end else begin : g_pass
      assign gp_o[i] = gp_i[i];
    end
  end
endmodule

// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone add/subtract with a valid/ready stream and full-pipeline stall.
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int LEVELS = clog2(WIDTH);
  localparam int LAT    = LEVELS + 2;
  gp_t  [WIDTH-1:0] gp_d [LEVELS+1];
  gp_t  [WIDTH-1:0] gp_q [LEVELS+1];
  logic [WIDTH-1:0] hp_d [LEVELS+1];
  logic [WIDTH-1:0] hp_q [LEVELS+1];
  logic [1:0]       sg_d [LEVELS+1];
  logic [1:0]       sg_q [LEVELS+1];
  logic [LAT-2:0]   cin_d, cin_q, vld_d, vld_q;
  logic [WIDTH-1:0] b_eff, sum_d, sum_q;
  logic [WIDTH:0]   c;
  logic             cout_d, cout_q, ovf_d, ovf_q, out_valid_d, out_valid_q, advance;
  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_gp
    assign gp_d[0][i] = '{g: a[i] & b_eff[i], p: a[i] ^ b_eff[i]};
  end
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    ks_prefix_level #(.WIDTH(WIDTH), .SPAN(1 << (l - 1))) u_lvl (
      .gp_i(gp_q[l-1]),
      .gp_o(gp_d[l])
    );
  end
  // The carry-in is the bit -1 node {g:cin, p:0}, combined onto every finished prefix.
  always_comb begin
    b_eff    = sub ? ~b : b;
    hp_d[0]  = a ^ b_eff;
    sg_d[0]  = {a[WIDTH-1], b_eff[WIDTH-1]};
    cin_d[0] = sub | cin;
    vld_d[0] = in_valid;
    for (int j = 1; j <= LEVELS; j++) begin
      hp_d[j]  = hp_q[j-1];
      sg_d[j]  = sg_q[j-1];
      cin_d[j] = cin_q[j-1];
      vld_d[j] = vld_q[j-1];
    end
    c[0] = cin_q[LEVELS];
    for (int i = 0; i < WIDTH; i++) c[i+1] = gp_q[LEVELS][i].g | (gp_q[LEVELS][i].p & cin_q[LEVELS]);
    sum_d       = hp_q[LEVELS] ^ c[WIDTH-1:0];
    cout_d      = c[WIDTH];
    ovf_d       = (sg_q[LEVELS][1] == sg_q[LEVELS][0]) && (sum_d[WIDTH-1] != sg_q[LEVELS][1]);
    out_valid_d = vld_q[LEVELS];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j <= LEVELS; j++) begin
        gp_q[j] <= '0;
        hp_q[j] <= '0;
        sg_q[j] <= '0;
      end
      cin_q       <= '0;
      vld_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (advance) begin
      gp_q        <= gp_d;
      hp_q        <= hp_d;
      sg_q        <= sg_d;
      cin_q       <= cin_d;
      vld_q       <= vld_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb_ks_adder_pipe: directed vectors, stall/reset sequences and random streams at widths 4/16/64.
module tb_ks_adder_pipe;
  localparam int W   = 16;
  localparam int LAT = 6;
  logic clk = 1'b0, rst = 1'b1, go = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, cout, ovf;
  logic [W-1:0] a = '0, b = '0, sum;
  int errs = 0, checks = 0, rnd_done = 0;

  ks_adder_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Reference: plain integer arithmetic; returns {cout, ovf, sum} with sum in the low 64 bits.
  function automatic logic [65:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                        input logic ci, input logic sb);
    logic [63:0] mask;
    logic [66:0] ux, uy, ur;
    logic signed [66:0] sx, sy, rs, lim;
    logic co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ux   = {3'b0, x & mask};
    uy   = {3'b0, y & mask};
    ur   = sb ? ux - uy : ux + uy + 67'(ci);
    co   = sb ? (ux >= uy) : ur[w];
    lim  = 67'sd1 <<< (w - 1);
    sx   = ux[w-1] ? $signed(ux) - (lim <<< 1) : $signed(ux);
    sy   = uy[w-1] ? $signed(uy) - (lim <<< 1) : $signed(uy);
    rs   = sb ? sx - sy : sx + sy + $signed(67'(ci));
    ov   = (rs >= lim) || (rs < -lim);
    return {co, ov, ur[63:0] & mask};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic cin, sub;
    logic [W-1:0] s;
    logic co, ov;
  } vec_t;
  vec_t vt[8];

  task automatic send_chk(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1; out_ready = 1'b1;
    chk({nm, " in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n + 1, LAT);
    chk({nm, " sum"}, sum, v.s);
    chk({nm, " cout"}, cout, v.co);
    chk({nm, " ovf"}, ovf, v.ov);
    @(posedge clk);
    @(negedge clk);
    chk({nm, " drained"}, out_valid, 0);
  endtask

  for (genvar w = 0; w < 3; w++) begin : g_rnd
    localparam int RW = (w == 0) ? 4 : (w == 1) ? 16 : 64;
    logic iv = 1'b0, ordy = 1'b0, ci = 1'b0, sb = 1'b0;
    logic ir, ov, co, of;
    logic [RW-1:0] ra = '0, rb = '0, sm;
    ks_adder_pipe #(.WIDTH(RW)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(ra), .b(rb),
      .cin(ci), .sub(sb), .out_valid(ov), .out_ready(ordy),
      .sum(sm), .cout(co), .ovf(of)
    );
    initial begin
      logic [65:0] q[$];
      logic [65:0] e;
      int nacc, cyc;
      nacc = 0;
      cyc  = 0;
      wait (go);
      while ((nacc < 10000 || q.size() != 0) && cyc < 60000) begin
        @(negedge clk);
        cyc++;
        iv   = (nacc < 10000) && ($urandom_range(3) != 0);
        ra   = RW'({$urandom, $urandom});
        rb   = RW'({$urandom, $urandom});
        ci   = 1'($urandom_range(1));
        sb   = 1'($urandom_range(1));
        ordy = $urandom_range(3) != 0;
        #1;
        if (iv && ir) begin
          nacc++;
          q.push_back(model(RW, 64'(ra), 64'(rb), ci, sb));
        end
        if (ov && ordy) begin
          checks++;
          if (q.size() == 0) begin
            errs++;
            $display("FAIL rnd%0d extra: got %0h with nothing expected", RW, sm);
          end else begin
            e = q.pop_front();
            if ({co, of, 64'(sm)} !== e) begin
              errs++;
              $display("FAIL rnd%0d result: got %0h expected %0h", RW, {co, of, 64'(sm)}, e);
            end
          end
        end
      end
      if (cyc >= 60000) begin
        errs++;
        $display("FAIL rnd%0d timeout: accepted %0d pending %0d", RW, nacc, q.size());
      end
      iv   = 1'b0;
      ordy = 1'b1;
      rnd_done++;
    end
  end

  initial begin
    logic [65:0] q[$];
    int acc, seen, n;
    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[2] = '{16'h0000, 16'h0009, 1'b1, 1'b0, 16'h000A, 1'b0, 1'b0};
    vt[3] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vt[4] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[6] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst outputs", {cout, ovf, sum}, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send_chk(vt[i], $sformatf("vec%0d", i));

    // Stall: 10 beats offered with the sink blocked.
    @(negedge clk);
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      a = 16'h1000 + 16'(i * 16'h0111); b = 16'(i * 7); sub = i[0]; cin = 1'b1; in_valid = 1'b1;
      #1;
      if (in_ready) begin
        acc++;
        q.push_back(model(W, 64'(a), 64'(b), cin, sub));
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp accepted", acc, 6);
    chk("bp in_ready", in_ready, 0);
    chk("bp out_valid", out_valid, 1);
    chk("bp head", {cout, ovf, 64'(sum)}, q[0]);
    repeat (3) @(negedge clk);
    chk("bp frozen", {out_valid, cout, ovf, 64'(sum)}, {1'b1, q[0]});
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("bp drain%0d valid", i), out_valid, 1);
      chk($sformatf("bp drain%0d data", i), {cout, ovf, 64'(sum)}, q.pop_front());
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp empty", out_valid, 0);

    // Reset with beats in flight and one already presented.
    for (int i = 0; i < 3; i++) begin
      a = 16'(i + 1); b = 16'h0002; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("pre_rst out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst out_valid", out_valid, 0);
    chk("mid_rst in_ready", in_ready, 1);
    chk("mid_rst outputs", {cout, ovf, sum}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("post_rst stale", seen, 0);
    send_chk(vt[2], "post_rst");

    go = 1'b1;
    for (int t = 0; t < 70000 && rnd_done < 3; t++) @(posedge clk);
    if (rnd_done < 3) begin
      errs++;
      $display("FAIL random done: got %0d streams finished expected 3", rnd_done);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
